jtag_ir_dr_path: RTL

//  Instruction/data-register datapath downstream of the TAP state controller. Consumes its decoded

---
 rtl/jtag_pkg.sv | 22 ++
 rtl/jtag_shift_reg.sv | 40 ++++
 rtl/jtag_ir_dr_path.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared constants for the JTAG instruction/data-register datapath: default IR width,
// opcode values, the IR capture pattern and the decoded-instruction type.
package jtag_pkg;

    localparam int IR_W_DEF = 4;

    // BYPASS is all ones at whatever IR width is used, so it is built in the top.
    localparam int unsigned OPC_EXTEST = 0;
    localparam int unsigned OPC_SAMPLE = 1;
    localparam int unsigned OPC_IDCODE = 2;
    localparam logic [IR_W_DEF-1:0] OPC_BYPASS = '1;

    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    typedef enum logic [1:0] {
        INSTR_EXTEST,
        INSTR_SAMPLE,
        INSTR_IDCODE,
        INSTR_BYPASS
    } instr_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift register with parallel load, shifting towards the LSB, which is the serial output.
module jtag_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    input  logic         sdi,
    output logic [W-1:0] q,
    output logic         so
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sr_d = sr_q;
        if (capture) begin
            sr_d = load_val;
        end else if (shift) begin
            sr_d = {sdi, sr_q[W-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q  = sr_q;
    assign so = sr_q[0];

endmodule

// File: rtl/jtag_ir_dr_path.sv
// JTAG IR/DR datapath behind the TAP controller: instruction register, decode, BYPASS/IDCODE
// data registers, boundary-scan controls and the registered TDO mux.
module jtag_ir_dr_path
    import jtag_pkg::*;
#(
    parameter int          IR_W       = IR_W_DEF,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            TDI,
    input  logic            select,
    input  logic            capture_ir,
    input  logic            shift_ir,
    input  logic            update_ir,
    input  logic            capture_dr,
    input  logic            shift_dr,
    input  logic            update_dr,
    input  logic            bsr_so,
    output logic            TDO,
    output logic            tdo_en,
    output logic [IR_W-1:0] ir_out,
    output logic            extest,
    output logic            bsr_capture,
    output logic            bsr_shift,
    output logic            bsr_update
);

    localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(OPC_EXTEST);
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(OPC_SAMPLE);
    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(OPC_IDCODE);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);

    logic [IR_W-1:0] ir_out_q, ir_out_d;
    logic            bypass_q, bypass_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;

    logic            ir_cap, ir_shf, ir_upd;
    logic            dr_cap, dr_shf, dr_upd;
    logic [IR_W-1:0] ir_sr;
    logic            ir_so;
    logic [31:0]     id_par_unused;
    logic            id_so;
    logic            bsr_sel;
    logic            shift_active;
    logic            serial_bit;
    instr_e          instr;

    // Within each path capture beats shift beats update; the inactive path sees nothing.
    assign ir_cap = select & capture_ir;
    assign ir_shf = select & shift_ir & ~capture_ir;
    assign ir_upd = select & update_ir & ~capture_ir & ~shift_ir;
    assign dr_cap = ~select & capture_dr;
    assign dr_shf = ~select & shift_dr & ~capture_dr;
    assign dr_upd = ~select & update_dr & ~capture_dr & ~shift_dr;

    always_comb begin
        case (ir_out_q)
            OP_EXTEST: instr = INSTR_EXTEST;
            OP_SAMPLE: instr = INSTR_SAMPLE;
            OP_IDCODE: instr = INSTR_IDCODE;
            default:   instr = INSTR_BYPASS;
        endcase
    end

    assign bsr_sel = (instr == INSTR_EXTEST) || (instr == INSTR_SAMPLE);

    jtag_shift_reg #(.W(IR_W)) u_ir_sr (
        .clk      (TCK),
        .rst      (TRST),
        .capture  (ir_cap),
        .shift    (ir_shf),
        .load_val (IR_CAPTURE),
        .sdi      (TDI),
        .q        (ir_sr),
        .so       (ir_so)
    );

    jtag_shift_reg #(.W(32)) u_id_sr (
        .clk      (TCK),
        .rst      (TRST),
        .capture  (dr_cap && instr == INSTR_IDCODE),
        .shift    (dr_shf && instr == INSTR_IDCODE),
        .load_val (IDCODE_VAL),
        .sdi      (TDI),
        .q        (id_par_unused),
        .so       (id_so)
    );

    always_comb begin
        if (select) begin
            serial_bit = ir_so;
        end else begin
            case (instr)
                INSTR_IDCODE: serial_bit = id_so;
                INSTR_BYPASS: serial_bit = bypass_q;
                default:      serial_bit = bsr_so;
            endcase
        end
    end

    assign shift_active = (shift_ir & select) | (shift_dr & ~select);

    always_comb begin
        ir_out_d = ir_out_q;
        bypass_d = bypass_q;
        tdo_d    = tdo_q;
        if (ir_upd) begin
            ir_out_d = ir_sr;
        end
        if (instr == INSTR_BYPASS) begin
            if (dr_cap) begin
                bypass_d = 1'b0;
            end else if (dr_shf) begin
                bypass_d = TDI;
            end
        end
        if (shift_active) begin
            tdo_d = serial_bit;
        end
        tdo_en_d = shift_active;
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_out_q <= OP_IDCODE;
            bypass_q <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_out_q <= ir_out_d;
            bypass_q <= bypass_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign ir_out      = ir_out_q;
    assign extest      = (instr == INSTR_EXTEST);
    assign bsr_capture = dr_cap & bsr_sel;
    assign bsr_shift   = dr_shf & bsr_sel;
    assign bsr_update  = dr_upd & bsr_sel;

endmodule
